mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU address, store data and funct3 from EX/MEM and performs the access over a req/gnt/rvalid data-memory bus.
- Produces byte-lane write data and enables, and sign- or zero-extends load data.
- Asserts a stall to the hazard unit until the access completes, then presents o_ReadData_M to the MEM/WB register.

Parameters:
- DATA_WIDTH, 32, data bus and register width.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+RSP before a bus error is declared; must be at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset.
- i_ALU_Res_M  in  ADDR_WIDTH  byte address.
- i_WriteData_M  in  DATA_WIDTH  store data from rs2.
- i_MemWrite_M  in  1  store request.
- i_MemRead_M  in  1  load request.
- i_Funct3_M  in  3  width and sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; for stores only 000, 001 and 010 are valid.
- i_Hold_M  in  1  external stall from the hazard unit; keeps DONE held.
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  ADDR_WIDTH  word-aligned address, low 2 bits always 0.
- o_dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- o_dmem_be  out  4  byte enables.
- i_dmem_gnt  in  1  request accepted.
- i_dmem_rvalid  in  1  read data valid.
- i_dmem_rdata  in  DATA_WIDTH  read data.
- o_ReadData_M  out  DATA_WIDTH  formatted load result, forwarded to MEM/WB.
- o_Stall_M  out  1  freeze fetch, decode, EX/MEM and the PC.
- o_Misaligned_M  out  1  one-cycle misaligned-access flag.
- o_BusErr_M  out  1  one-cycle timeout flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst; all state changes on the rising edge of clk.
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; timeout counter goes to 0.
  - o_dmem_req=0, o_dmem_we=0, o_dmem_addr=0, o_dmem_wdata=0, o_dmem_be=0.
  - o_ReadData_M=0, o_Stall_M=0, o_Misaligned_M=0, o_BusErr_M=0.
  - Reset mid-transaction abandons it. An rvalid arriving later in IDLE is ignored.
- Op present = i_MemRead_M | i_MemWrite_M. If both are high, it is treated as a load.
- Misaligned access:
  - Conditions: lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0.
  - In IDLE: no bus request, o_Misaligned_M=1 for one cycle, stall stays 0, o_ReadData_M=0, state remains IDLE.
- State IDLE:
  - Aligned op present: o_Stall_M=1 combinationally.
  - Register addr, be, wdata, funct3 and we; go to REQ.
- State REQ:
  - o_dmem_req=1; all bus outputs held stable until gnt.
  - On gnt, a store goes to DONE and a load goes to RSP.
  - gnt and rvalid in the same cycle for a load: capture the data, go to DONE.
- State RSP:
  - On rvalid, format i_dmem_rdata and register it into o_ReadData_M; go to DONE.
- State DONE:
  - o_Stall_M=0; o_ReadData_M is valid (0 for stores).
  - If i_Hold_M=1, stay in DONE; otherwise go to IDLE next cycle.
- o_Stall_M=1 in REQ and RSP.
- Timeout:
  - The counter increments in REQ and RSP and clears on entry to DONE.
  - When it reaches TIMEOUT_CYCLES-1 without completion: drop req, o_BusErr_M=1 for one cycle, o_ReadData_M=0, go to DONE.
- Store lanes, with off = addr[1:0]:
  - sb: be = 4'b0001<<off; wdata = byte replicated 4 times.
  - sh: be = 4'b0011<<(2*addr[1]); wdata = half replicated 2 times.
  - sw: be = 4'b1111.
- Load format:
  - lb/lbu: select byte rdata[8*off+:8]; lb sign-extends, lbu zero-extends.
  - lh/lhu: select half rdata[16*addr[1]+:16]; lh sign-extends, lhu zero-extends.
  - lw: pass rdata through.
- Unused funct3 codes behave as lw or sw.

Decomposition:
- Shared package riscv_pkg holds:
  - the funct3 load/store constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW);
  - the lsu_state_t enum (IDLE, REQ, RSP, DONE).
- Sub-module lsu_align is purely combinational: misalign detect, be/wdata generation and load extension. It is reused by a future cache.
- mem_stage_lsu keeps the FSM, the timeout counter and the registers.

Test Plan:
- sw addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle -> req for 1 cycle, be=1111, stall high 2 cycles, DONE, o_ReadData_M=0.
- lb addr 0x203, rdata 0x80FF7F01, gnt immediate, rvalid 2 cycles later -> o_dmem_addr=0x200, o_ReadData_M=0xFFFFFF80.
- Repeat the previous load as lbu -> 0x00000080. lhu addr 0x202 -> 0x000080FF. lh -> 0xFFFF80FF.
- sh addr 0x206 data 0x1234ABCD -> be=1100, wdata=0xABCDABCD.
- lw addr 0x102 -> no req, o_Misaligned_M pulse, stall 0.
- Load with gnt never asserted, TIMEOUT_CYCLES=16 -> req high 15 cycles, o_BusErr_M pulse, o_ReadData_M=0.
- Separately, rst in RSP -> next cycle IDLE with all outputs 0; a late rvalid is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Load/store funct3 codes and LSU state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic for the LSU.
// Misalign detect, store lanes, load extension.
import riscv_pkg::*;

module lsu_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_off,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [2:0]            i_ld_funct3,
  input  logic [1:0]            i_ld_off,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_misaligned,
  output logic [3:0]            o_be,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic       w_byte;
  logic       w_half;
  logic       w_ld_byte;
  logic       w_ld_half;
  logic       w_ld_sx;
  logic [7:0]  w_b;
  logic [15:0] w_h;

  // Stores only know sb/sh/sw; the unsigned codes fall to word.
  assign w_byte = (i_funct3 == F3_SB) ||
                  (!i_we && i_funct3 == F3_LBU);
  assign w_half = (i_funct3 == F3_SH) ||
                  (!i_we && i_funct3 == F3_LHU);

  assign w_ld_byte = (i_ld_funct3[1:0] == 2'b00);
  assign w_ld_half = (i_ld_funct3[1:0] == 2'b01);
  assign w_ld_sx   = ~i_ld_funct3[2];

  assign w_b = i_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_h = i_rdata[{i_ld_off[1], 4'b0000} +: 16];

  // Access size decode: misalignment, byte enables, lane replication.
  always_comb begin
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    unique case (1'b1)
      w_byte: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      w_half: begin
        o_misaligned = i_off[0];
        o_be         = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      default: o_misaligned = |i_off;
    endcase
  end

  // Load lane select with sign or zero extension.
  always_comb begin
    o_rdata = i_rdata;
    unique case (1'b1)
      w_ld_byte: o_rdata = {{24{w_ld_sx & w_b[7]}}, w_b};
      w_ld_half: o_rdata = {{16{w_ld_sx & w_h[15]}}, w_h};
      default:   o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Drives the req/gnt/rvalid data bus and stalls the pipe.
import riscv_pkg::*;

module mem_stage_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_ALU_Res_M,
  input  logic [DATA_WIDTH-1:0] i_WriteData_M,
  input  logic                  i_MemWrite_M,
  input  logic                  i_MemRead_M,
  input  logic [2:0]            i_Funct3_M,
  input  logic                  i_Hold_M,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_ReadData_M,
  output logic                  o_Stall_M,
  output logic                  o_Misaligned_M,
  output logic                  o_BusErr_M
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t r_state;
  lsu_state_t w_next;

  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [3:0]            r_be;
  logic [2:0]            r_funct3;
  logic                  r_we;

  logic                  w_op;
  logic                  w_we;
  logic                  w_mis;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ldfmt;
  logic                  w_busy;
  logic                  w_timeout;
  logic                  w_capture;
  logic                  w_stall;
  logic                  w_req;
  logic                  w_buserr;
  logic                  w_misout;

  // A simultaneous read and write is handled as a load.
  assign w_op = i_MemRead_M | i_MemWrite_M;
  assign w_we = i_MemWrite_M & ~i_MemRead_M;

  assign w_busy    = (r_state == REQ) || (r_state == RSP);
  assign w_timeout = w_busy &&
                     (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .i_we         (w_we),
    .i_funct3     (i_Funct3_M),
    .i_off        (i_ALU_Res_M[1:0]),
    .i_wdata      (i_WriteData_M),
    .i_ld_funct3  (r_funct3),
    .i_ld_off     (r_addr[1:0]),
    .i_rdata      (i_dmem_rdata),
    .o_misaligned (w_mis),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_ldfmt)
  );

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_stall   = 1'b0;
    w_req     = 1'b0;
    w_buserr  = 1'b0;
    w_misout  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_op) begin
          if (w_mis) begin
            w_misout = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = REQ;
          end
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (w_timeout) begin
          w_buserr = 1'b1;
          w_next   = DONE;
        end else begin
          w_req = 1'b1;
          if (i_dmem_gnt) begin
            if (r_we) begin
              w_next = DONE;
            end else if (i_dmem_rvalid) begin
              w_capture = 1'b1;
              w_next    = DONE;
            end else begin
              w_next = RSP;
            end
          end
        end
      end
      RSP: begin
        w_stall = 1'b1;
        if (i_dmem_rvalid) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else if (w_timeout) begin
          w_buserr = 1'b1;
          w_next   = DONE;
        end
      end
      DONE: begin
        if (!i_Hold_M) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, request latch, timeout counter and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_be     <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == REQ) begin
        r_addr   <= i_ALU_Res_M;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_funct3 <= i_Funct3_M;
        r_we     <= w_we;
      end
      if (w_busy && w_next != DONE) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_capture) begin
        r_rdata <= w_ldfmt;
      end else if (w_next == IDLE) begin
        r_rdata <= '0;
      end
    end
  end

  assign o_dmem_req     = w_req;
  assign o_dmem_we      = r_we;
  assign o_dmem_addr    = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign o_dmem_wdata   = r_wdata;
  assign o_dmem_be      = r_be;
  assign o_ReadData_M   = r_rdata;
  assign o_Stall_M      = w_stall;
  assign o_Misaligned_M = w_misout;
  assign o_BusErr_M     = w_buserr;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu.
// Hand-computed vectors, immediate assertions.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic [31:0] i_ALU_Res_M;
  logic [31:0] i_WriteData_M;
  logic        i_MemWrite_M;
  logic        i_MemRead_M;
  logic [2:0]  i_Funct3_M;
  logic        i_Hold_M;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_ReadData_M;
  logic        o_Stall_M;
  logic        o_Misaligned_M;
  logic        o_BusErr_M;

  int n_run;
  int n_fail;

  mem_stage_lsu #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_ALU_Res_M    (i_ALU_Res_M),
    .i_WriteData_M  (i_WriteData_M),
    .i_MemWrite_M   (i_MemWrite_M),
    .i_MemRead_M    (i_MemRead_M),
    .i_Funct3_M     (i_Funct3_M),
    .i_Hold_M       (i_Hold_M),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .o_dmem_addr    (o_dmem_addr),
    .o_dmem_wdata   (o_dmem_wdata),
    .o_dmem_be      (o_dmem_be),
    .i_dmem_gnt     (i_dmem_gnt),
    .i_dmem_rvalid  (i_dmem_rvalid),
    .i_dmem_rdata   (i_dmem_rdata),
    .o_ReadData_M   (o_ReadData_M),
    .o_Stall_M      (o_Stall_M),
    .o_Misaligned_M (o_Misaligned_M),
    .o_BusErr_M     (o_BusErr_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_run++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic do_store(input logic [2:0]  f3,
                          input logic [31:0] addr,
                          input logic [31:0] data,
                          input logic [3:0]  be,
                          input logic [31:0] wd);
    i_MemWrite_M  = 1'b1;
    i_Funct3_M    = f3;
    i_ALU_Res_M   = addr;
    i_WriteData_M = data;
    @(negedge clk);
    chk("st_idle_stall", 32'(o_Stall_M), 32'd1);
    chk("st_idle_req", 32'(o_dmem_req), 32'd0);
    tick();
    i_dmem_gnt = 1'b1;
    @(negedge clk);
    chk("st_req", 32'(o_dmem_req), 32'd1);
    chk("st_we", 32'(o_dmem_we), 32'd1);
    chk("st_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
    chk("st_be", 32'(o_dmem_be), 32'(be));
    chk("st_wdata", o_dmem_wdata, wd);
    chk("st_req_stall", 32'(o_Stall_M), 32'd1);
    tick();
    i_dmem_gnt   = 1'b0;
    i_MemWrite_M = 1'b0;
    @(negedge clk);
    chk("st_done_stall", 32'(o_Stall_M), 32'd0);
    chk("st_done_req", 32'(o_dmem_req), 32'd0);
    chk("st_done_rd", o_ReadData_M, 32'd0);
    tick();
  endtask

  task automatic do_load(input logic [2:0]  f3,
                         input logic [31:0] addr,
                         input logic [31:0] rdata,
                         input logic [31:0] want);
    i_MemRead_M = 1'b1;
    i_Funct3_M  = f3;
    i_ALU_Res_M = addr;
    @(negedge clk);
    chk("ld_idle_stall", 32'(o_Stall_M), 32'd1);
    tick();
    i_dmem_gnt = 1'b1;
    @(negedge clk);
    chk("ld_req", 32'(o_dmem_req), 32'd1);
    chk("ld_we", 32'(o_dmem_we), 32'd0);
    chk("ld_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
    tick();
    i_dmem_gnt = 1'b0;
    @(negedge clk);
    chk("ld_rsp_req", 32'(o_dmem_req), 32'd0);
    chk("ld_rsp_stall", 32'(o_Stall_M), 32'd1);
    tick();
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = rdata;
    tick();
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = 32'h0;
    i_MemRead_M   = 1'b0;
    @(negedge clk);
    chk("ld_data", o_ReadData_M, want);
    chk("ld_done_stall", 32'(o_Stall_M), 32'd0);
    tick();
  endtask

  initial begin
    int  nreq;
    bit  seen;
    n_run         = 0;
    n_fail        = 0;
    rst           = 1'b1;
    i_ALU_Res_M   = '0;
    i_WriteData_M = '0;
    i_MemWrite_M  = 1'b0;
    i_MemRead_M   = 1'b0;
    i_Funct3_M    = 3'b000;
    i_Hold_M      = 1'b0;
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_we", 32'(o_dmem_we), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_be", 32'(o_dmem_be), 32'd0);
    chk("rst_rd", o_ReadData_M, 32'd0);
    chk("rst_stall", 32'(o_Stall_M), 32'd0);
    chk("rst_mis", 32'(o_Misaligned_M), 32'd0);
    chk("rst_berr", 32'(o_BusErr_M), 32'd0);
    tick();

    do_store(3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_load(3'b000, 32'h203, 32'h80FF7F01, 32'hFFFFFF80);
    do_load(3'b100, 32'h203, 32'h80FF7F01, 32'h00000080);
    do_load(3'b101, 32'h202, 32'h80FF7F01, 32'h000080FF);
    do_load(3'b001, 32'h202, 32'h80FF7F01, 32'hFFFF80FF);
    do_load(3'b000, 32'h201, 32'h80FF7F01, 32'h0000007F);
    do_store(3'b001, 32'h206, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
    do_store(3'b000, 32'h101, 32'h0000005A, 4'b0010, 32'h5A5A5A5A);

    i_MemRead_M = 1'b1;
    i_Funct3_M  = 3'b010;
    i_ALU_Res_M = 32'h102;
    @(negedge clk);
    chk("mis_flag", 32'(o_Misaligned_M), 32'd1);
    chk("mis_req", 32'(o_dmem_req), 32'd0);
    chk("mis_stall", 32'(o_Stall_M), 32'd0);
    chk("mis_rd", o_ReadData_M, 32'd0);
    tick();
    i_MemRead_M = 1'b0;
    @(negedge clk);
    chk("mis_gone", 32'(o_Misaligned_M), 32'd0);
    chk("mis_idle_req", 32'(o_dmem_req), 32'd0);
    tick();

    i_MemRead_M = 1'b1;
    i_Funct3_M  = 3'b010;
    i_ALU_Res_M = 32'h300;
    tick();
    i_dmem_gnt    = 1'b1;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'h11223344;
    @(negedge clk);
    chk("same_req", 32'(o_dmem_req), 32'd1);
    tick();
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = 32'h0;
    i_MemRead_M   = 1'b0;
    i_Hold_M      = 1'b1;
    @(negedge clk);
    chk("same_rd", o_ReadData_M, 32'h11223344);
    chk("same_stall", 32'(o_Stall_M), 32'd0);
    tick();
    @(negedge clk);
    chk("hold_rd", o_ReadData_M, 32'h11223344);
    chk("hold_req", 32'(o_dmem_req), 32'd0);
    i_Hold_M = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_rd", o_ReadData_M, 32'd0);
    tick();

    i_MemRead_M = 1'b1;
    i_Funct3_M  = 3'b010;
    i_ALU_Res_M = 32'h400;
    tick();
    nreq = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_BusErr_M) begin
        seen = 1'b1;
        chk("to_err_req", 32'(o_dmem_req), 32'd0);
        chk("to_err_rd", o_ReadData_M, 32'd0);
        break;
      end
      if (o_dmem_req) nreq++;
      tick();
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_req_cycles", 32'(nreq), 32'd15);
    tick();
    i_MemRead_M = 1'b0;
    @(negedge clk);
    chk("to_done_stall", 32'(o_Stall_M), 32'd0);
    chk("to_done_berr", 32'(o_BusErr_M), 32'd0);
    chk("to_done_rd", o_ReadData_M, 32'd0);
    tick();

    i_MemRead_M = 1'b1;
    i_Funct3_M  = 3'b010;
    i_ALU_Res_M = 32'h504;
    tick();
    i_dmem_gnt = 1'b1;
    tick();
    i_dmem_gnt = 1'b0;
    @(negedge clk);
    chk("rr_rsp_stall", 32'(o_Stall_M), 32'd1);
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    i_MemRead_M = 1'b0;
    @(negedge clk);
    chk("rr_req", 32'(o_dmem_req), 32'd0);
    chk("rr_addr", o_dmem_addr, 32'd0);
    chk("rr_be", 32'(o_dmem_be), 32'd0);
    chk("rr_stall", 32'(o_Stall_M), 32'd0);
    chk("rr_rd", o_ReadData_M, 32'd0);
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'hCAFEF00D;
    tick();
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = 32'h0;
    @(negedge clk);
    chk("late_rd", o_ReadData_M, 32'd0);
    chk("late_stall", 32'(o_Stall_M), 32'd0);
    chk("late_req", 32'(o_dmem_req), 32'd0);
    tick();

    do_load(3'b010, 32'h600, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
